// File: rtl/rstseq_pkg.sv
// Shared types and defaults for the CPU reset sequencer: FSM states, reset-cause codes, helpers.
// Optional feature macro used by the top: RSTSEQ_CAUSE_LOG_EN (sticky per-cause log).
package rstseq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_EXT = 2'd1;
  localparam logic [1:0] CAUSE_WDT = 2'd2;
  localparam logic [1:0] CAUSE_SW  = 2'd3;

  localparam int DEF_N_STAGES       = 4;
  localparam int DEF_STRETCH_CYCLES = 4;
  localparam int DEF_STAGE_GAP      = 2;
  localparam int DEF_DEB_CYCLES     = 3;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Simultaneous requests resolve EXT > WDT > SW.
  function automatic logic [1:0] req_cause(input logic ext, input logic wdt);
    if (ext) begin
      return CAUSE_EXT;
    end else if (wdt) begin
      return CAUSE_WDT;
    end else begin
      return CAUSE_SW;
    end
  endfunction

  function automatic logic [3:0] cause_onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/reset_sequencer_debounce.sv
// Push-button conditioner: two-flop synchroniser, then a run of DEB_CYCLES synchronised highs
// yields a single accept pulse; it re-arms only once the synchronised input has gone low.
module rst_debounce #(
  parameter int DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic Rst,
  input  logic raw,
  output logic acc
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [1:0]       sync_r;
  logic [DEB_W-1:0] cnt_r;
  logic [DEB_W-1:0] cnt_s;
  logic             acc_r;
  logic             acc_s;

  // Synchroniser, run counter and accept pulse registers.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      sync_r <= 2'b00;
      cnt_r  <= {DEB_W{1'b0}};
      acc_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], raw};
      cnt_r  <= cnt_s;
      acc_r  <= acc_s;
    end
  end

  // Count consecutive highs; saturating at DEB_CYCLES blocks a second pulse while held.
  always_comb begin
    cnt_s = cnt_r;
    acc_s = 1'b0;
    if (sync_r[1]) begin
      if (cnt_r == DEB_W'(DEB_CYCLES - 1)) begin
        cnt_s = DEB_W'(DEB_CYCLES);
        acc_s = 1'b1;
      end else if (cnt_r < DEB_W'(DEB_CYCLES)) begin
        cnt_s = cnt_r + DEB_W'(1);
      end else begin
        cnt_s = cnt_r;
      end
    end else begin
      cnt_s = {DEB_W{1'b0}};
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/reset_sequencer.sv
// Central CPU reset controller: merges reset requests, stretches reset, releases unit resets in order.
// Define RSTSEQ_CAUSE_LOG_EN to add cause_clr / cause_log (sticky per-cause history).
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int N_STAGES       = DEF_N_STAGES,
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int STAGE_GAP      = DEF_STAGE_GAP,
  parameter int DEB_CYCLES     = DEF_DEB_CYCLES
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic                ext_rst_req,
  input  logic                wdt_rst_req,
  input  logic                sw_rst_req,
`ifdef RSTSEQ_CAUSE_LOG_EN
  input  logic                cause_clr,
`endif
  output logic [N_STAGES-1:0] stage_rst_n,
  output logic                cpu_ready,
  output logic                busy,
  output logic [1:0]          rst_cause
`ifdef RSTSEQ_CAUSE_LOG_EN
  ,
  output logic [3:0]          cause_log
`endif
);

  localparam int CNT_W = $clog2(max_int(STRETCH_CYCLES, STAGE_GAP) + 1);

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [N_STAGES-1:0] stage_r, stage_s;
  logic                ready_r, ready_s;
  logic                busy_r, busy_s;
  logic [1:0]          cause_r, cause_s;
  logic                ext_acc_s;
  logic                req_s;

  rst_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk (clk),
    .Rst (Rst),
    .raw (ext_rst_req),
    .acc (ext_acc_s)
  );

  assign req_s = ext_acc_s | wdt_rst_req | sw_rst_req;

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_r <= ASSERT;
      cnt_r   <= {CNT_W{1'b0}};
      stage_r <= {N_STAGES{1'b0}};
      ready_r <= 1'b0;
      busy_r  <= 1'b1;
      cause_r <= CAUSE_POR;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      stage_r <= stage_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
      cause_r <= cause_s;
    end
  end

  // Next state; any request from any state restarts the whole sequence.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    stage_s = stage_r;
    ready_s = ready_r;
    busy_s  = busy_r;
    cause_s = cause_r;
    if (req_s) begin
      state_s = ASSERT;
      cnt_s   = {CNT_W{1'b0}};
      stage_s = {N_STAGES{1'b0}};
      ready_s = 1'b0;
      busy_s  = 1'b1;
      cause_s = req_cause(ext_acc_s, wdt_rst_req);
    end else begin
      case (state_r)
        ASSERT: begin
          stage_s = {N_STAGES{1'b0}};
          ready_s = 1'b0;
          busy_s  = 1'b1;
          if (cnt_r == CNT_W'(STRETCH_CYCLES - 1)) begin
            cnt_s   = {CNT_W{1'b0}};
            stage_s = {{(N_STAGES-1){1'b0}}, 1'b1};
            state_s = RELEASE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_r == CNT_W'(STAGE_GAP - 1)) begin
            cnt_s   = {CNT_W{1'b0}};
            stage_s = {stage_r[N_STAGES-2:0], 1'b1};
            if (stage_r[N_STAGES-2]) begin
              state_s = DONE;
            end else begin
              state_s = RELEASE;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          stage_s = {N_STAGES{1'b1}};
          ready_s = 1'b1;
          busy_s  = 1'b0;
          state_s = RUN;
        end
        RUN: begin
          stage_s = {N_STAGES{1'b1}};
          ready_s = 1'b1;
          busy_s  = 1'b0;
        end
        default: begin
          state_s = ASSERT;
          cnt_s   = {CNT_W{1'b0}};
          stage_s = {N_STAGES{1'b0}};
          ready_s = 1'b0;
          busy_s  = 1'b1;
        end
      endcase
    end
  end

  assign stage_rst_n = stage_r;
  assign cpu_ready   = ready_r;
  assign busy        = busy_r;
  assign rst_cause   = cause_r;

`ifdef RSTSEQ_CAUSE_LOG_EN
  logic [3:0] log_r, log_s;

  // Sticky cause history; clear is applied first so a same-cycle set survives.
  always_comb begin
    log_s = log_r;
    if (cause_clr) begin
      log_s = 4'b0000;
    end else begin
      log_s = log_r;
    end
    if (req_s) begin
      log_s = log_s | cause_onehot(req_cause(ext_acc_s, wdt_rst_req));
    end else begin
      log_s = log_s;
    end
  end

  // Cause log register; power-on reset records POR.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      log_r <= cause_onehot(CAUSE_POR);
    end else begin
      log_r <= log_s;
    end
  end

  assign cause_log = log_r;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer (default build, cause log disabled).
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       Rst;
  logic       ext_rst_req;
  logic       wdt_rst_req;
  logic       sw_rst_req;
  logic [3:0] stage_rst_n;
  logic       cpu_ready;
  logic       busy;
  logic [1:0] rst_cause;

  int checks = 0;
  int errors = 0;

  reset_sequencer dut (
    .clk         (clk),
    .Rst         (Rst),
    .ext_rst_req (ext_rst_req),
    .wdt_rst_req (wdt_rst_req),
    .sw_rst_req  (sw_rst_req),
    .stage_rst_n (stage_rst_n),
    .cpu_ready   (cpu_ready),
    .busy        (busy),
    .rst_cause   (rst_cause)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stage vector e edges after the reset/request edge (defaults S=4, G=2).
  function automatic logic [3:0] exp_stage(input int e);
    if (e >= 10)     return 4'b1111;
    else if (e >= 8) return 4'b0111;
    else if (e >= 6) return 4'b0011;
    else if (e >= 4) return 4'b0001;
    else             return 4'b0000;
  endfunction

  task automatic run_seq(input string tag, input logic [1:0] cause);
    for (int e = 1; e <= 11; e++) begin
      tick();
      check_eq({tag, "_stage"}, 32'(stage_rst_n), 32'(exp_stage(e)));
      check_eq({tag, "_ready"}, 32'(cpu_ready), 32'(e >= 11));
      check_eq({tag, "_busy"}, 32'(busy), 32'(e < 11));
    end
    check_eq({tag, "_cause"}, 32'(rst_cause), 32'(cause));
  endtask

  task automatic check_asserted(input string tag, input logic [1:0] cause);
    check_eq({tag, "_stage0"}, 32'(stage_rst_n), 32'h0);
    check_eq({tag, "_ready0"}, 32'(cpu_ready), 32'h0);
    check_eq({tag, "_busy0"}, 32'(busy), 32'h1);
    check_eq({tag, "_cause0"}, 32'(rst_cause), 32'(cause));
  endtask

  initial begin
    Rst = 1'b0; ext_rst_req = 1'b0; wdt_rst_req = 1'b0; sw_rst_req = 1'b0;
    repeat (3) tick();
    check_asserted("por_hold", 2'd0);
    Rst = 1'b1;
    run_seq("por", 2'd0);

    // Software reset from RUN
    sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
    check_asserted("sw", 2'd3);
    run_seq("sw", 2'd3);

    // Short button press is filtered out
    ext_rst_req = 1'b1; repeat (2) tick(); ext_rst_req = 1'b0;
    repeat (8) tick();
    check_eq("ext_short_stage", 32'(stage_rst_n), 32'hF);
    check_eq("ext_short_ready", 32'(cpu_ready), 32'h1);
    check_eq("ext_short_cause", 32'(rst_cause), 32'h3);

    // Long press: sync (2) + 3 highs + registered pulse -> taken on 6th edge
    ext_rst_req = 1'b1;
    repeat (5) tick();
    check_eq("ext_pre_stage", 32'(stage_rst_n), 32'hF);
    tick();
    check_asserted("ext", 2'd1);
    run_seq("ext", 2'd1);
    ext_rst_req = 1'b0;
    repeat (6) tick();
    check_eq("ext_once_stage", 32'(stage_rst_n), 32'hF);
    check_eq("ext_once_busy", 32'(busy), 32'h0);

    // WDT beats SW
    wdt_rst_req = 1'b1; sw_rst_req = 1'b1; tick();
    wdt_rst_req = 1'b0; sw_rst_req = 1'b0;
    check_asserted("wdt", 2'd2);
    run_seq("wdt", 2'd2);

    // Request during RELEASE restarts the sequence
    sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
    repeat (6) tick();
    check_eq("mid_stage", 32'(stage_rst_n), 32'h3);
    sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
    check_asserted("restart", 2'd3);
    run_seq("restart", 2'd3);

    // Rst mid-RELEASE overrides and records POR
    sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
    repeat (8) tick();
    check_eq("pre_rst_stage", 32'(stage_rst_n), 32'h7);
    Rst = 1'b0; tick();
    check_asserted("rst_mid", 2'd0);
    Rst = 1'b1;
    run_seq("por2", 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
